// File: rtl/move_decoder.sv
// move_decoder
//   Receiver end of the board-position code stream. Keeps the previous
//   position and, for every accepted 4-bit position code, recovers the 2-bit
//   move that produced it by inverting the forward transition table. Decoded
//   moves are queued in a small FIFO that the move logger / scoring logic
//   drains.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid & ready are both 1. Valid and data hold until that edge. Ready never
//   depends combinationally on the other side's valid or ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pos_valid/ready   position input handshake (ready = FIFO not full)
//   pos_code[3:0]     new position, legal 0..8
//   resync            on accept: load pos_code as previous position, no decode
//   move_valid/ready  FIFO head handshake
//   move[1:0]         decoded move at FIFO head (0 when empty)
//   err, err_clr      sticky error flag and its clear (set wins over clear)
//   move_cnt          saturating count of decoded moves
module move_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pos_valid,
  output logic             pos_ready,
  input  logic [3:0]       pos_code,
  input  logic             resync,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [1:0]       move,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] move_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [3:0]       prev_q, prev_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept, push, pop, err_event;
  logic       code_legal, hit;
  logic [1:0] hit_m;

  // Forward transition T(P, M) of the next-state logic this block inverts.
  function automatic logic [3:0] next_pos(input logic [3:0] p, input logic [1:0] m);
    logic [3:0] r;
    r = 4'd0;
    if (p <= 4'd4) begin
      case (m)
        2'd0:    r = p;
        2'd1:    r = p + 4'd1;
        2'd2:    r = p + 4'd2;
        default: r = p + 4'd4;
      endcase
    end else if (p <= 4'd8) begin
      case (m)
        2'd0:    r = 4'd0;
        2'd1:    r = p - 4'd4;
        2'd2:    r = p - 4'd3;
        default: r = p - 4'd1;
      endcase
    end
    return r;
  endfunction

  // Inverse search: at most one M matches for prev in 0..8.
  always_comb begin
    hit   = 1'b0;
    hit_m = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (next_pos(prev_q, 2'(i)) == pos_code) begin
        hit   = 1'b1;
        hit_m = 2'(i);
      end
    end
  end

  assign code_legal = (pos_code <= 4'd8);
  assign accept     = pos_valid & pos_ready;
  assign push       = accept & ~resync & hit & code_legal;
  assign pop        = move_valid & move_ready;
  assign err_event  = accept & (resync ? ~code_legal : ~(hit & code_legal));

  always_comb begin
    prev_d   = prev_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    // Every accepted legal code becomes the new reference, whether it was a
    // resync, a clean decode or an undecodable jump.
    if (accept && code_legal) prev_d = pos_code;

    if (push) begin
      mem_d[wr_ptr_q] = hit_m;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d  = (count_d == DEPTH_C);

    if (err_clr)   err_d = 1'b0;
    if (err_event) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Registered full flag keeps pos_ready free of any path from move_ready.
  assign pos_ready  = ~full_q;
  assign move_valid = (count_q != '0);
  assign move       = move_valid ? mem_q[rd_ptr_q] : 2'd0;
  assign err        = err_q;
  assign move_cnt   = cnt_q;

endmodule
